proc_trace_capture: RTL
=======================

// Module: proc_trace_capture
// PURPOSE
//  Synthesizable, parametrised on-chip trace capture for the pipelined processor.
//  Samples NUM_CH watched channels (pc, data_writeReg, address_dmem, ...) into a buffer.
//  Capture starts on a pc/value trigger and ends on a cycle limit, a full buffer or an abort.
//  Captured entries are read out through a pop handshake; sits beside skeleton, fed by probe wires.
// PARAMETERS
//  NUM_CH       4    number of watched channels
//  CH_W         32   width of each channel
//  DEPTH        64   buffer entries (power of 2, >=2)
//  CNT_W        16   cycle counter / timestamp width
// PORTS
//  clock        in   1                  rising-edge clock
//  reset        in   1                  synchronous, active-high
//  arm          in   1                  pulse: IDLE/DONE -> ARMED
//  abort        in   1                  force DONE from ARMED/CAPTURE
//  mode         in   1                  0 = record every cycle, 1 = record on change only
//  wrap_en      in   1                  0 = stop when full, 1 = circular overwrite
//  trig_ch      in   $clog2(NUM_CH)     channel compared for trigger
//  trig_value   in   CH_W               trigger match value
//  cycle_limit  in   CNT_W              capture cycles before DONE; 0 = unlimited
//  ch_data      in   NUM_CH*CH_W        channel k at bits [k*CH_W +: CH_W]
//  rd_en        in   1                  pop oldest entry (honoured only in DONE)
//  rd_valid     out  1                  rd_data/rd_ts valid this cycle
//  rd_data      out  NUM_CH*CH_W        popped entry
//  rd_ts        out  CNT_W              capture-cycle timestamp of popped entry
//  count        out  $clog2(DEPTH)+1    entries held
//  overflow     out  1                  oldest entries were overwritten
//  done         out  1                  high while state == DONE
//  state        out  2                  IDLE=0 ARMED=1 CAPTURE=2 DONE=3
// BEHAVIOUR
//  Reset: state IDLE; count, overflow, done, rd_valid, rd_data, rd_ts all 0; reset mid-capture discards buffer.
//  IDLE: arm -> ARMED; clears wr/rd pointers, count, cycle counter, overflow.
//  ARMED: trigger when ch_data[trig_ch] == trig_value; that cycle's sample is written as entry 0
//   (ts 0) and state -> CAPTURE next edge. trig_ch >= NUM_CH never triggers. arm ignored.
//  CAPTURE: cycle counter increments every cycle (trigger cycle = 0). Write when mode=0, or mode=1
//   and ch_data != last written entry. When counter+1 == cycle_limit (nonzero) -> DONE; the
//   limiting cycle is still recorded. Capture window = exactly cycle_limit cycles.
//  Full, wrap_en=0: write making count == DEPTH -> DONE same edge. wrap_en=1: overwrite oldest,
//   advance rd pointer, count stays DEPTH, overflow sets sticky until next arm.
//  abort in ARMED/CAPTURE -> DONE next edge; a same-cycle write still occurs. abort ignored elsewhere.
//  Simultaneous limit/full/abort: single transition to DONE, one write at most.
//  DONE: rd_en with count>0 -> rd_valid=1 next cycle, rd_data/rd_ts = oldest entry, count-1.
//   rd_en with count==0 ignored, rd_valid 0. Entries emerge oldest-first. arm in DONE re-arms,
//   discards remainder. rd_valid is a 1-cycle pulse per pop; back-to-back pops allowed.
//  Cycle counter saturates at 2^CNT_W-1 when cycle_limit==0.
// CONFIGURATION
//  TRACE_TIMESTAMP_EN defined: buffer width NUM_CH*CH_W+CNT_W, rd_ts = counter at write.
//  Not defined: no timestamp storage, rd_ts tied to 0; all other behaviour identical.
// STRUCTURE
//  Shared package trace_defs.vh: state encodings TR_IDLE/TR_ARMED/TR_CAPTURE/TR_DONE,
//   MODE_ALL/MODE_CHANGE constants.
//  Sub-module trace_ram: simple dual-port RAM, one sync write port, one sync read port (1-cycle latency).
//  Top holds FSM, pointers, counters, change detector.
// TESTING
//  NUM_CH=4, DEPTH=8. mode=0, cycle_limit=5, trigger pc==12 at cycle 3 -> 5 entries, done at
//   trigger+5, pops return pc 12..16 with ts 0..4.
//  mode=1, pc held 20 for 4 cycles then 24, limit=6 -> count=2 entries (20 ts0, 24 ts4).
//  wrap_en=1, limit=0, abort after 11 captured cycles -> count=8, overflow=1, first pop = 4th sample.
//  wrap_en=0, limit=0 -> DONE on the edge of 8th write, count=8, overflow=0.
//  reset asserted mid-CAPTURE at count=3 -> next cycle state=0, count=0, rd_valid=0.
//  rd_en when count=0 in DONE -> rd_valid stays 0; arm in DONE -> state=1, count=0.
//  Rebuild without TRACE_TIMESTAMP_EN -> same entries, rd_ts always 0.

Source files
------------

// File: rtl/proc_trace_capture_pkg.sv
// Shared definitions for the processor trace-capture block: FSM state encoding and
// recording-mode constants.
package proc_trace_capture_pkg;

  typedef enum logic [1:0] {
    TrIdle    = 2'd0,
    TrArmed   = 2'd1,
    TrCapture = 2'd2,
    TrDone    = 2'd3
  } tr_state_e;

  localparam logic ModeAll    = 1'b0;
  localparam logic ModeChange = 1'b1;

endpackage

// File: rtl/proc_trace_capture_ram.sv
// Simple dual-port trace buffer: one synchronous write port and one synchronous read port
// with a single cycle of read latency.
module proc_trace_capture_ram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/proc_trace_capture.sv
// On-chip trace capture: triggers on a channel/value match, records channel samples into a
// circular buffer, then drains them oldest-first. Define TRACE_TIMESTAMP_EN to store timestamps.
module proc_trace_capture
  import proc_trace_capture_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      arm,
  input  logic                      abort,
  input  logic                      mode,
  input  logic                      wrap_en,
  input  logic [$clog2(NUM_CH)-1:0] trig_ch,
  input  logic [CH_W-1:0]           trig_value,
  input  logic [CNT_W-1:0]          cycle_limit,
  input  logic [NUM_CH*CH_W-1:0]    ch_data,
  input  logic                      rd_en,
  output logic                      rd_valid,
  output logic [NUM_CH*CH_W-1:0]    rd_data,
  output logic [CNT_W-1:0]          rd_ts,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      done,
  output logic [1:0]                state
);

  localparam int unsigned DW = NUM_CH * CH_W;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(NUM_CH);
`ifdef TRACE_TIMESTAMP_EN
  localparam int unsigned RW = DW + CNT_W;
`else
  localparam int unsigned RW = DW;
`endif
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  tr_state_e        state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             overflow_q, overflow_d;
  logic             rd_valid_q, rd_valid_d;
  logic [DW-1:0]    last_q, last_d;

  logic          trig_hit, limit_hit;
  logic          do_write, go_done, rearm;
  logic          we, re;
  logic [RW-1:0] wdata, rdata;

  // A trig_ch that names no channel simply never matches.
  always_comb begin
    trig_hit = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (trig_ch == TW'(k) && ch_data[k*CH_W +: CH_W] == trig_value) begin
        trig_hit = 1'b1;
      end
    end
  end

  assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  assign limit_hit = (cycle_limit != '0) &&
                     ((CNT_W+1)'(cnt_q) + (CNT_W+1)'(1) == (CNT_W+1)'(cycle_limit));

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    last_d     = last_q;
    rd_valid_d = 1'b0;
    do_write   = 1'b0;
    go_done    = 1'b0;
    rearm      = 1'b0;
    we         = 1'b0;
    re         = 1'b0;

    unique case (state_q)
      TrIdle: rearm = arm;
      TrArmed: begin
        do_write = trig_hit;
        if (trig_hit) begin
          state_d = TrCapture;
          cnt_d   = cnt_inc;
        end
        go_done = abort || (trig_hit && limit_hit);
      end
      TrCapture: begin
        do_write = (mode == ModeAll) || (ch_data != last_q);
        cnt_d    = cnt_inc;
        go_done  = abort || limit_hit;
      end
      TrDone: begin
        if (arm) begin
          rearm = 1'b1;
        end else if (rd_en && count_q != '0) begin
          re         = 1'b1;
          rd_ptr_d   = rd_ptr_q + AW'(1);
          count_d    = count_q - CW'(1);
          rd_valid_d = 1'b1;
        end
      end
      default: state_d = TrIdle;
    endcase

    if (do_write) begin
      if (count_q == FULL) begin
        if (wrap_en) begin
          // Overwrite the oldest entry; the read pointer follows so order is preserved.
          we         = 1'b1;
          last_d     = ch_data;
          wr_ptr_d   = wr_ptr_q + AW'(1);
          rd_ptr_d   = rd_ptr_q + AW'(1);
          overflow_d = 1'b1;
        end else begin
          go_done = 1'b1;
        end
      end else begin
        we       = 1'b1;
        last_d   = ch_data;
        wr_ptr_d = wr_ptr_q + AW'(1);
        count_d  = count_q + CW'(1);
        if (count_q == FULL - CW'(1) && !wrap_en) begin
          go_done = 1'b1;
        end
      end
    end

    if (go_done) begin
      state_d = TrDone;
    end

    if (rearm) begin
      state_d    = TrArmed;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      cnt_d      = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= TrIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      rd_valid_q <= rd_valid_d;
      last_q     <= last_d;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  assign wdata = {cnt_q, ch_data};
`else
  assign wdata = ch_data;
`endif

  proc_trace_capture_ram #(
    .WIDTH(RW),
    .DEPTH(DEPTH)
  ) u_ram (
    .clock(clock),
    .we   (we),
    .waddr(wr_ptr_q),
    .wdata(wdata),
    .re   (re),
    .raddr(rd_ptr_q),
    .rdata(rdata)
  );

  // RAM output is unreset, so it is only exposed during the valid pulse.
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_valid_q ? rdata[DW-1:0] : '0;
`ifdef TRACE_TIMESTAMP_EN
  assign rd_ts    = rd_valid_q ? rdata[RW-1 -: CNT_W] : '0;
`else
  assign rd_ts    = '0;
`endif
  assign count    = count_q;
  assign overflow = overflow_q;
  assign done     = (state_q == TrDone);
  assign state    = state_q;

endmodule
